disp_arbiter: RTL and testbench

DISP_ARBITER -- requirements
Module: disp_arbiter

---
 rtl/disp_arbiter.sv | 99 +++++++++
 tb/tb_disp_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/disp_arbiter.sv
// Two-requester round-robin owner of a 16-bit seven-segment display value with a fixed dwell per grant.
// Optional macro DISP_ARB_PREEMPT_EN lets requester 0 cut short a grant held by requester 1.
module disp_arbiter #(
  parameter int unsigned DWELL_CYC = 50000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  req_i,
  input  logic [15:0] data0_i,
  input  logic [15:0] data1_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  done_o,
  output logic [15:0] reg_16_o,
  output logic        valid_o
);

  localparam int unsigned CW = $clog2(DWELL_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYC - 1);

  typedef enum logic [1:0] {IDLE, SHOW, RELEASE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          last, last_n;
  logic [1:0]    gnt_n, done_n;
  logic [15:0]   reg_n;
  logic          valid_n;
  logic          win;
  logic          owner_req;
  logic          preempt;

  // During SHOW, 'last' is the current owner.
  assign owner_req = last ? req_i[1] : req_i[0];
  assign win       = (req_i == 2'b11) ? ~last : req_i[1];

`ifdef DISP_ARB_PREEMPT_EN
  // After a preempted requester-1 grant the pointer is 1, so requester 0 wins the next tie.
  assign preempt = last & req_i[0];
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
    gnt_n   = gnt_o;
    done_n  = '0;
    reg_n   = reg_16_o;
    valid_n = valid_o;
    case (state)
      IDLE: begin
        if (req_i != 2'b00) begin
          state_n = SHOW;
          gnt_n   = win ? 2'b10 : 2'b01;
          valid_n = 1'b1;
          reg_n   = win ? data1_i : data0_i;
          cnt_n   = '0;
          last_n  = win;
        end
      end
      SHOW: begin
        if (cnt == CNT_LAST || !owner_req || preempt) begin
          state_n = RELEASE;
          gnt_n   = '0;
          valid_n = 1'b0;
          done_n  = last ? 2'b10 : 2'b01;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
          reg_n = last ? data1_i : data0_i;
        end
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= 1'b1;
      gnt_o    <= '0;
      done_o   <= '0;
      reg_16_o <= '0;
      valid_o  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      last     <= last_n;
      gnt_o    <= gnt_n;
      done_o   <= done_n;
      reg_16_o <= reg_n;
      valid_o  <= valid_n;
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter (DWELL_CYC=4): per-cycle behavioural model plus literal spot checks.
module tb_disp_arbiter;

  localparam int DWELL = 4;
`ifdef DISP_ARB_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  req_i = 2'b11;
  logic [15:0] data0_i = 16'hAAAA;
  logic [15:0] data1_i = 16'hBBBB;
  logic [1:0]  gnt_o, done_o;
  logic [15:0] reg_16_o;
  logic        valid_o;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  disp_arbiter #(.DWELL_CYC(DWELL)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .data0_i  (data0_i),
    .data1_i  (data1_i),
    .gnt_o    (gnt_o),
    .done_o   (done_o),
    .reg_16_o (reg_16_o),
    .valid_o  (valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model: owner index (-1 none), cycles shown, release-gap flag, last owner.
  int          m_own = -1;
  int          m_shown = 0;
  bit          m_rel = 1'b0;
  int          m_last = 1;
  logic [1:0]  exp_gnt = '0, exp_done = '0;
  logic        exp_valid = 1'b0;
  logic [15:0] exp_reg = '0;

  initial forever begin
    @(posedge clk_i);
    exp_done = '0;
    if (rst_i) begin
      m_own = -1; m_rel = 1'b0; m_last = 1;
      exp_gnt = '0; exp_valid = 1'b0; exp_reg = '0;
    end else if (m_own >= 0) begin
      m_shown++;
      if (m_shown == DWELL || !req_i[m_own] || (PRE && m_own == 1 && req_i[0])) begin
        exp_done  = (m_own == 1) ? 2'b10 : 2'b01;
        exp_gnt   = '0;
        exp_valid = 1'b0;
        m_own     = -1;
        m_rel     = 1'b1;
      end else begin
        exp_reg = (m_own == 1) ? data1_i : data0_i;
      end
    end else if (m_rel) begin
      m_rel = 1'b0;
    end else if (req_i != 2'b00) begin
      m_own     = (req_i == 2'b11) ? 1 - m_last : (req_i[1] ? 1 : 0);
      m_last    = m_own;
      m_shown   = 0;
      exp_gnt   = (m_own == 1) ? 2'b10 : 2'b01;
      exp_valid = 1'b1;
      exp_reg   = (m_own == 1) ? data1_i : data0_i;
    end
  end

  always @(negedge clk_i) begin
    if (chk_on) begin
      check("model_gnt",   {14'd0, gnt_o},  {14'd0, exp_gnt});
      check("model_done",  {14'd0, done_o}, {14'd0, exp_done});
      check("model_valid", {15'd0, valid_o}, {15'd0, exp_valid});
      check("model_reg",   reg_16_o, exp_reg);
    end
  end

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  logic [1:0] pat [12] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00,
                           2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};

  initial begin
    // Reset held 3 cycles with requests and data active
    step; chk_on = 1'b1;
    step; step;
    check("rst_gnt",   {14'd0, gnt_o},  16'h0000);
    check("rst_done",  {14'd0, done_o}, 16'h0000);
    check("rst_valid", {15'd0, valid_o}, 16'h0000);
    check("rst_reg",   reg_16_o, 16'h0000);
    rst_i = 1'b0;
    step;
    check("first_gnt", {14'd0, gnt_o}, 16'h0001);

    // Alternation with both requesting
    for (int k = 1; k <= 12; k++) begin
      step;
      check("alt_gnt", {14'd0, gnt_o}, {14'd0, pat[k % 12]});
      if (k == 4)  check("alt_done0", {14'd0, done_o}, 16'h0001);
      if (k == 10) check("alt_done1", {14'd0, done_o}, 16'h0002);
    end
    req_i = 2'b00;
    step; step;

    // Live data tracking for requester 1
    data1_i = 16'h1234; req_i = 2'b10;
    step;
    check("live_gnt",   {14'd0, gnt_o}, 16'h0002);
    check("live_valid", {15'd0, valid_o}, 16'h0001);
    check("live_reg0",  reg_16_o, 16'h1234);
    data1_i = 16'h5678;
    step;
    check("live_reg1",  reg_16_o, 16'h5678);
    step; step; step;
    check("live_done",  {14'd0, done_o}, 16'h0002);
    check("live_hold",  reg_16_o, 16'h5678);
    req_i = 2'b00;
    step;
    check("idle_reg",   reg_16_o, 16'h5678);
    check("idle_valid", {15'd0, valid_o}, 16'h0000);

    // Early drop by requester 0 after two SHOW cycles
    req_i = 2'b01;
    step;
    check("drop_gnt0", {14'd0, gnt_o}, 16'h0001);
    step;
    req_i = 2'b00;
    step;
    check("drop_done", {14'd0, done_o}, 16'h0001);
    check("drop_gnt",  {14'd0, gnt_o}, 16'h0000);
    step;

    // Requester 0 rises during requester 1's first SHOW cycle
    req_i = 2'b10;
    step;
    check("pre_own1", {14'd0, gnt_o}, 16'h0002);
    req_i = 2'b11;
`ifdef DISP_ARB_PREEMPT_EN
    step;
    check("pre_done", {14'd0, done_o}, 16'h0002);
    step; step;
    check("pre_gnt0", {14'd0, gnt_o}, 16'h0001);
`else
    step;
    check("nopre_gnt", {14'd0, gnt_o}, 16'h0002);
    step; step; step;
    check("nopre_done", {14'd0, done_o}, 16'h0002);
    step; step;
    check("nopre_gnt0", {14'd0, gnt_o}, 16'h0001);
`endif

    // Reset during SHOW cycle 2 drops the grant without a done pulse
    step;
    rst_i = 1'b1;
    step;
    check("mrst_gnt",   {14'd0, gnt_o},  16'h0000);
    check("mrst_valid", {15'd0, valid_o}, 16'h0000);
    check("mrst_reg",   reg_16_o, 16'h0000);
    check("mrst_done",  {14'd0, done_o}, 16'h0000);
    rst_i = 1'b0;
    step;
    check("mrst_ptr",   {14'd0, gnt_o},  16'h0001);
    req_i = 2'b00;
    step; step; step;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
